vector_harvester: RTL and testbench
===================================

// Module: vector_harvester
// PURPOSE
//  Collects results from the output buffers of a bank of PE_COUNT processing elements and drains them to one stream.
//  Each PE exposes out_empty/out (head word) and takes a read_from_output pop strobe.
//  Round-robin arbitration over non-empty PEs; results are tagged with the PE index and sent on a valid/ready port.
//  A job is a fixed number of results. done pulses once the last result is accepted downstream.
// PARAMETERS
//  PE_COUNT   8   number of PEs served (>=2)
//  CNT_W      16  width of job result counter
// PORTS
//  clk               in   1              system clock, all logic on rising edge
//  reset             in   1              synchronous, active-high reset
//  start             in   1              1-cycle pulse: begin job, latch total_count
//  total_count       in   CNT_W          results to collect this job
//  busy              out  1              job in progress
//  done              out  1              1-cycle pulse: job complete
//  out_empty         in   PE_COUNT       per-PE output buffer empty
//  pe_out            in   PE_COUNT x 32  per-PE buffer head word (first-word-fall-through)
//  read_from_output  out  PE_COUNT       per-PE pop strobe, at most one bit high
//  res_valid         out  1              result word available
//  res_ready         in   1              downstream accepts when valid&ready
//  res_data          out  32             result word
//  res_idx           out  $clog2(PE_COUNT) source PE index
// BEHAVIOUR
//  Reset (synchronous): state=IDLE, busy=0, done=0, read_from_output=0, res_valid=0, res_data=0,
//  res_idx=0, rr_ptr=0, counters=0. A reset asserted mid-job abandons the job and returns to IDLE.
//  PE buffer contract: pe_out[i] is valid whenever out_empty[i]=0. A pop strobe in cycle t removes the head, and the
//  new head/empty state is visible in cycle t+1.
//  FSM: IDLE -> start: latch total_count into remaining, issued=0.
//    total_count==0: go to FIN, so done pulses in the next cycle. Otherwise go to RUN.
//  RUN: pop_ok = (issued < total) && (!res_valid || res_ready).
//    If pop_ok and any out_empty[i]=0: grant the first non-empty index at or after rr_ptr, wrapping modulo PE_COUNT.
//    Assert read_from_output[g] in that cycle (combinational). Next cycle: res_data=pe_out[g], res_idx=g, res_valid=1.
//    Also set rr_ptr=(g+1)%PE_COUNT and issued++.
//  Handshake: res_valid stays high with res_data/res_idx held stable until res_ready=1.
//    A pop plus an acceptance in the same cycle replaces the output register. Sustained rate is 1 result/cycle.
//  accepted counts valid&ready. When accepted reaches total: RUN -> FIN. FIN: done=1 for one cycle, then IDLE.
//  No pops while issued==total: excess PE data stays in the PE buffers.
//  busy=1 in RUN and FIN. start while busy is ignored.
//  All PEs empty: no pop, rr_ptr is unchanged, and the block waits indefinitely (no timeout).
//  Simultaneous last acceptance and reset: reset wins, so there is no done pulse.
//  Counters are CNT_W bits. total_count is at most 2^CNT_W-1, so no wrap occurs.
// STRUCTURE
//  harvester_pkg: typedef enum {IDLE,RUN,FIN} harv_state_t; localparam DATA_W=32; idx width helper function.
//  Sub-module rr_arbiter #(N): req[N], ptr, en -> one-hot grant, grant_idx, any.
//    Combinational double-width priority mask. Shared with the future planter-side distributor.
//  Top level holds the FSM, issued/accepted counters, rr_ptr and the output register.
// TESTING
//  1 Reset, start total=4, PE0..3 each one word 0xA0+i, ready=1 -> res_idx 0,1,2,3 in consecutive cycles.
//    done pulses 1 cycle after the 4th acceptance.
//  2 All PEs non-empty, rr_ptr=5, PE_COUNT=8 -> grant order 5,6,7,0,1,..; no PE is granted twice before the others.
//  3 Backpressure: ready=0 for 10 cycles with valid high -> res_data is stable and there are zero pops.
//    Ready back to 1 -> pops resume at 1/cycle.
//  4 total=3 with 5 words available -> exactly 3 pops, done pulses once, 2 words remain (out_empty=0).
//  5 start with total=0 -> done pulses in the next cycle with no pops. start pulsed again while busy is ignored.
//  6 Reset asserted mid-job after 2 of 6 results -> next cycle all outputs are at reset values and there is no done.
//    A new start then works.

Source files
------------

// File: rtl/harvester_pkg.sv
// Shared types for the PE result harvester and its round-robin arbiter.
package harvester_pkg;

  typedef enum logic [1:0] {IDLE, RUN, FIN} harv_state_t;

  localparam int DATA_W = 32;

  // Index width that stays at least one bit for degenerate sizes.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first set request at or after ptr, wrapping; combinational, zero latency.
// No backpressure of its own: en gates the grant, any reports pending requests regardless of en.
module rr_arbiter
  import harvester_pkg::*;
#(
  parameter  int N  = 8,
  localparam int IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          any
);

  logic [2*N-1:0] dbl_req;
  logic [2*N-1:0] masked;
  logic           found;

  // Doubling the request vector turns the wrap-around search into one linear scan.
  always_comb begin
    dbl_req   = {req, req};
    masked    = dbl_req & ({(2*N){1'b1}} << ptr);
    any       = |req;
    found     = 1'b0;
    grant_idx = '0;
    for (int i = 0; i < 2*N; i++) begin
      if (!found && masked[i]) begin
        found     = 1'b1;
        grant_idx = IW'(i % N);
      end
    end
    grant = '0;
    if (en && any) grant[grant_idx] = 1'b1;
  end

endmodule

// File: rtl/vector_harvester.sv
// Drains PE output buffers round-robin into one tagged valid/ready stream; pop to res_valid is 1 cycle.
// Holds the output register under backpressure and pops nothing until it can be replaced or is accepted.
module vector_harvester
  import harvester_pkg::*;
#(
  parameter  int PE_COUNT = 8,
  parameter  int CNT_W    = 16,
  localparam int IW       = idx_w(PE_COUNT)
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               start,
  input  logic [CNT_W-1:0]                   total_count,
  output logic                               busy,
  output logic                               done,
  input  logic [PE_COUNT-1:0]                out_empty,
  input  logic [PE_COUNT-1:0][DATA_W-1:0]    pe_out,
  output logic [PE_COUNT-1:0]                read_from_output,
  output logic                               res_valid,
  input  logic                               res_ready,
  output logic [DATA_W-1:0]                  res_data,
  output logic [IW-1:0]                      res_idx
);

  harv_state_t        state, state_nxt;
  logic [CNT_W-1:0]   job_total, issued, accepted;
  logic [IW-1:0]      rr_ptr, grant_idx;
  logic [PE_COUNT-1:0] grant;
  logic               any, pop_ok, pop, accept, last_accept;

  // Reset gates the pop so a PE never loses a word the harvester is about to forget.
  assign pop_ok      = !reset && (state == RUN) && (issued < job_total) && (!res_valid || res_ready);
  assign pop         = pop_ok && any;
  assign accept      = res_valid && res_ready;
  assign last_accept = accept && ((accepted + CNT_W'(1)) == job_total);

  rr_arbiter #(.N(PE_COUNT)) u_arb (
    .req       (~out_empty),
    .ptr       (rr_ptr),
    .en        (pop_ok),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any       (any)
  );

  assign read_from_output = grant;
  assign busy             = (state != IDLE);
  assign done             = (state == FIN);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (total_count == '0) ? FIN : RUN;
      RUN:     if (last_accept) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      job_total <= '0;
      issued    <= '0;
      accepted  <= '0;
      rr_ptr    <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_idx   <= '0;
    end else begin
      if (state == IDLE && start) begin
        job_total <= total_count;
        issued    <= '0;
        accepted  <= '0;
      end
      if (pop) begin
        res_valid <= 1'b1;
        res_data  <= pe_out[grant_idx];
        res_idx   <= grant_idx;
        rr_ptr    <= (grant_idx == IW'(PE_COUNT - 1)) ? '0 : grant_idx + IW'(1);
        issued    <= issued + CNT_W'(1);
      end else if (accept) begin
        res_valid <= 1'b0;
      end
      if (accept) accepted <= accepted + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_vector_harvester.sv
// Randomized bench for vector_harvester against a queue-based behavioural model.
module tb_vector_harvester;

  localparam int NPE = 8;

  logic                     clk = 1'b0;
  logic                     reset, start, res_ready;
  logic [15:0]              total_count;
  logic                     busy, done, res_valid;
  logic [NPE-1:0]           out_empty, rfo;
  logic [NPE-1:0][31:0]     pe_out;
  logic [31:0]              res_data;
  logic [2:0]               res_idx;

  vector_harvester #(.PE_COUNT(NPE), .CNT_W(16)) dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .total_count      (total_count),
    .busy             (busy),
    .done             (done),
    .out_empty        (out_empty),
    .pe_out           (pe_out),
    .read_from_output (rfo),
    .res_valid        (res_valid),
    .res_ready        (res_ready),
    .res_data         (res_data),
    .res_idx          (res_idx)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int cyc = 0, pops = 0, dones = 0, last_done_cyc = 0;
  bit chk_en = 1'b0;

  logic [31:0] peq [NPE][$];
  int          log_idx[$];
  logic [31:0] log_data[$];
  int          log_cyc[$];

  // Model state: 0 idle, 1 collecting, 2 finishing
  int          m_state = 0, m_ptr = 0, m_issued = 0, m_acc = 0, m_total = 0, m_idx = 0;
  bit          m_valid = 1'b0;
  logic [31:0] m_data = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic refresh();
    for (int i = 0; i < NPE; i++) begin
      out_empty[i] = (peq[i].size() == 0);
      pe_out[i]    = (peq[i].size() != 0) ? peq[i][0] : (32'hDEAD_0000 | 32'(i));
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    #1 refresh();
  end

  always @(negedge clk) begin
    int g;
    logic [NPE-1:0] exp_rfo;
    bit acc;
    g = -1;
    if (!reset && m_state == 1 && m_issued < m_total && (!m_valid || res_ready))
      for (int k = 0; k < NPE; k++) begin
        int j;
        j = (m_ptr + k) % NPE;
        if (g < 0 && peq[j].size() > 0) g = j;
      end
    exp_rfo = (g >= 0) ? (NPE'(1) << g) : '0;
    if (chk_en) begin
      check("busy", 64'(busy), 64'(m_state != 0));
      check("done", 64'(done), 64'(m_state == 2));
      check("res_valid", 64'(res_valid), 64'(m_valid));
      check("read_from_output", 64'(rfo), 64'(exp_rfo));
      if (m_valid) begin
        check("res_data", 64'(res_data), 64'(m_data));
        check("res_idx", 64'(res_idx), 64'(m_idx));
      end
    end
    if (rfo != '0) pops++;
    if (done) begin dones++; last_done_cyc = cyc; end
    if (reset) begin
      m_state = 0; m_ptr = 0; m_issued = 0; m_acc = 0; m_total = 0;
      m_valid = 1'b0; m_data = '0; m_idx = 0;
    end else begin
      acc = m_valid && res_ready;
      if (acc) begin
        log_idx.push_back(m_idx); log_data.push_back(m_data); log_cyc.push_back(cyc);
        m_acc++;
      end
      case (m_state)
        0: if (start) begin
             m_total = int'(total_count); m_issued = 0; m_acc = 0;
             m_state = (total_count == 0) ? 2 : 1;
           end
        2: m_state = 0;
        default: begin
          if (g >= 0) begin
            m_valid = 1'b1; m_data = peq[g][0]; m_idx = g;
            m_ptr = (g + 1) % NPE; m_issued++;
            void'(peq[g].pop_front());
          end else if (acc) m_valid = 1'b0;
          if (acc && m_acc == m_total) m_state = 2;
        end
      endcase
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic push(input int pe, input logic [31:0] w);
    peq[pe].push_back(w);
    refresh();
  endtask

  task automatic clear_all();
    for (int i = 0; i < NPE; i++) peq[i].delete();
    refresh();
  endtask

  task automatic clear_log();
    log_idx.delete(); log_data.delete(); log_cyc.delete();
  endtask

  task automatic start_job(input int n);
    total_count = 16'(n); start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int d0, n;
    d0 = dones; n = 0;
    while (dones == d0 && n < budget) begin tick(); n++; end
    check({name, "_done_seen"}, 64'(dones > d0), 64'd1);
  endtask

  initial begin
    int p0, d0, n, remaining_push;
    logic [31:0] held;
    reset = 1'b1; start = 1'b0; total_count = '0; res_ready = 1'b1;
    clear_all();
    tick();
    chk_en = 1'b1;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_valid", 64'(res_valid), 64'd0);
    check("reset_data", 64'(res_data), 64'd0);
    check("reset_idx", 64'(res_idx), 64'd0);
    check("reset_rfo", 64'(rfo), 64'd0);
    tick();
    reset = 1'b0;
    tick();

    // 1: four single-word PEs drained in order, one per cycle
    for (int i = 0; i < 4; i++) push(i, 32'hA0 + 32'(i));
    clear_log();
    start_job(4);
    wait_done("t1", 50);
    check("t1_count", 64'(log_idx.size()), 64'd4);
    for (int i = 0; i < 4 && i < log_idx.size(); i++) begin
      check("t1_idx", 64'(log_idx[i]), 64'(i));
      check("t1_data", 64'(log_data[i]), 64'(32'hA0 + 32'(i)));
      if (i > 0) check("t1_back_to_back", 64'(log_cyc[i] - log_cyc[i-1]), 64'd1);
    end
    if (log_cyc.size() == 4) check("t1_done_lag", 64'(last_done_cyc - log_cyc[3]), 64'd1);

    // 2: move pointer to 5, then all PEs full
    push(4, 32'h44);
    start_job(1);
    wait_done("t2a", 50);
    for (int i = 0; i < NPE; i++) begin push(i, $urandom); push(i, $urandom); end
    clear_log();
    start_job(8);
    wait_done("t2", 80);
    check("t2_count", 64'(log_idx.size()), 64'd8);
    for (int i = 0; i < 8 && i < log_idx.size(); i++)
      check("t2_order", 64'(log_idx[i]), 64'((5 + i) % 8));

    // 3: backpressure holds data and stops pops
    res_ready = 1'b0;
    start_job(4);
    n = 0;
    while (!res_valid && n < 20) begin tick(); n++; end
    check("t3_valid_up", 64'(res_valid), 64'd1);
    held = res_data; p0 = pops;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("t3_stable", 64'(res_data), 64'(held));
    end
    check("t3_no_pops", 64'(pops - p0), 64'd0);
    clear_log();
    res_ready = 1'b1;
    wait_done("t3", 50);
    check("t3_pops_after", 64'(pops - p0), 64'd3);
    for (int i = 1; i < log_cyc.size(); i++)
      check("t3_rate", 64'(log_cyc[i] - log_cyc[i-1]), 64'd1);

    // 4: fewer results than words available
    clear_all();
    for (int i = 0; i < 5; i++) push(2, 32'h400 + 32'(i));
    p0 = pops; d0 = dones;
    start_job(3);
    wait_done("t4", 50);
    repeat (5) tick();
    check("t4_pops", 64'(pops - p0), 64'd3);
    check("t4_dones", 64'(dones - d0), 64'd1);
    check("t4_left", 64'(peq[2].size()), 64'd2);
    check("t4_not_empty", 64'(out_empty[2]), 64'd0);

    // 5: zero-length job, then start while busy
    clear_all();
    p0 = pops;
    start_job(0);
    check("t5_done_next", 64'(done), 64'd1);
    tick();
    check("t5_done_once", 64'(done), 64'd0);
    check("t5_no_pops", 64'(pops - p0), 64'd0);
    clear_log();
    start_job(2);
    repeat (3) tick();
    start_job(7);
    push(1, 32'h51); push(6, 32'h56);
    wait_done("t5", 50);
    repeat (3) tick();
    check("t5_ignored_start", 64'(log_idx.size()), 64'd2);
    check("t5_idle", 64'(busy), 64'd0);

    // 6: reset mid-job
    clear_all();
    for (int i = 0; i < 6; i++) push(i, 32'h600 + 32'(i));
    clear_log();
    start_job(6);
    n = 0;
    while (log_idx.size() < 2 && n < 20) begin tick(); n++; end
    check("t6_two_accepted", 64'(log_idx.size()), 64'd2);
    d0 = dones;
    reset = 1'b1;
    tick();
    check("t6_busy", 64'(busy), 64'd0);
    check("t6_valid", 64'(res_valid), 64'd0);
    check("t6_data", 64'(res_data), 64'd0);
    check("t6_idx", 64'(res_idx), 64'd0);
    check("t6_rfo", 64'(rfo), 64'd0);
    reset = 1'b0;
    repeat (5) tick();
    check("t6_no_done", 64'(dones - d0), 64'd0);
    start_job(3);
    wait_done("t6_restart", 50);

    // Random jobs with random readiness, arrivals and stray starts
    clear_all();
    for (int job = 0; job < 25; job++) begin
      n = $urandom_range(0, 12);
      remaining_push = n;
      start_job(n);
      d0 = dones;
      p0 = 0;
      while (dones == d0 && p0 < 600) begin
        res_ready = ($urandom_range(0, 3) != 0);
        start = ($urandom_range(0, 7) == 0);
        total_count = 16'($urandom_range(0, 20));
        if (remaining_push > 0 && $urandom_range(0, 1) == 1) begin
          push($urandom_range(0, NPE - 1), $urandom);
          remaining_push--;
        end
        tick();
        p0++;
      end
      start = 1'b0;
      res_ready = 1'b1;
      check("rand_done_seen", 64'(dones > d0), 64'd1);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
